// File: rtl/tt_sweep_pkg.sv
// Shared types and sizes for the 4-input truth-table sweep/capture block.
package tt_sweep_pkg;

  localparam int VEC_BITS  = 4;
  localparam int VEC_COUNT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/tt_settle_timer.sv
// Settle-window counter: restarts on load, counts while run is high and
// produces a one-cycle expire pulse in the last of SETTLE_CYCLES run cycles.
module tt_settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_run,
  output logic o_expire
);

  logic [7:0] count;

  assign o_expire = i_run && (count == 8'(SETTLE_CYCLES - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count <= '0;
    end else if (i_load || o_expire) begin
      count <= '0;
    end else if (i_run) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/tt_sweep_capture.sv
// Sweeps all 16 vectors of a 4-input unit, captures the response truth table
// and compares it with a table latched at start. Optional first-failure
// reporting is enabled by defining TT_SWEEP_FIRST_FAIL_EN.
module tt_sweep_capture
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [VEC_COUNT-1:0] i_expected,
  input  logic                 i_y,
  output logic                 o_a,
  output logic                 o_b,
  output logic                 o_c,
  output logic                 o_d,
  output logic [VEC_COUNT-1:0] o_table,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
`ifdef TT_SWEEP_FIRST_FAIL_EN
  output logic                 o_fail_valid,
  output logic [VEC_BITS-1:0]  o_first_fail,
`endif
  output logic [1:0]           o_state
);

  localparam logic [VEC_BITS-1:0] LAST_VEC = VEC_BITS'(VEC_COUNT - 1);

  state_t               state, state_next;
  logic [VEC_BITS-1:0]  vector;
  logic [VEC_COUNT-1:0] expected_q;
  logic [VEC_COUNT-1:0] table_next;
  logic                 start_ok;
  logic                 timer_load;
  logic                 expire;

  assign {o_a, o_b, o_c, o_d} = vector;
  assign o_state = state;

  tt_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_load   (timer_load),
    .i_run    (state == SETTLE),
    .o_expire (expire)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_ok   = 1'b0;
    case (state)
      IDLE, DONE: if (i_start) begin
        start_ok   = 1'b1;
        state_next = SETTLE;
      end
      SETTLE: if (expire) state_next = SAMPLE;
      SAMPLE: state_next = (vector == LAST_VEC) ? DONE : SETTLE;
      default: state_next = IDLE;
    endcase
    timer_load = start_ok || (state == SAMPLE && vector != LAST_VEC);
    // The pass compare must see the bit being written this cycle.
    table_next         = o_table;
    table_next[vector] = i_y;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vector     <= '0;
      o_table    <= '0;
      expected_q <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_pass     <= 1'b0;
    end else if (start_ok) begin
      vector     <= '0;
      o_table    <= '0;
      expected_q <= i_expected;
      o_busy     <= 1'b1;
      o_done     <= 1'b0;
      o_pass     <= 1'b0;
    end else if (state == SAMPLE) begin
      o_table <= table_next;
      if (vector == LAST_VEC) begin
        o_busy <= 1'b0;
        o_done <= 1'b1;
        o_pass <= (table_next == expected_q);
      end else begin
        vector <= vector + 1'b1;
      end
    end
  end

`ifdef TT_SWEEP_FIRST_FAIL_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_fail_valid <= 1'b0;
      o_first_fail <= '0;
    end else if (start_ok) begin
      o_fail_valid <= 1'b0;
      o_first_fail <= '0;
    end else if (state == SAMPLE && !o_fail_valid && (i_y != expected_q[vector])) begin
      o_fail_valid <= 1'b1;
      o_first_fail <= vector;
    end
  end
`endif

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Self-checking bench for tt_sweep_capture: scoreboarded sweeps, latency,
// reset, held start, late expected-table changes and a SETTLE_CYCLES=1 build.
module tb_tt_sweep_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] expected;
  logic        y;
  logic        a, b, c, d;
  logic [15:0] tbl;
  logic        busy, done, pass;
  logic [1:0]  st;
  int          mode;

  logic        start1;
  logic [15:0] expected1;
  logic        y1;
  logic        a1, b1, c1, d1;
  logic [15:0] tbl1;
  logic        busy1, done1, pass1;
  logic [1:0]  st1;

`ifdef TT_SWEEP_FIRST_FAIL_EN
  logic       fail_valid, fail_valid1;
  logic [3:0] first_fail, first_fail1;
`endif

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q[$];
  logic        pass_q[$];
  logic        ffv_q[$];
  logic [3:0]  ff_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  tt_sweep_capture #(.SETTLE_CYCLES(2)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_expected(expected), .i_y(y),
    .o_a(a), .o_b(b), .o_c(c), .o_d(d), .o_table(tbl),
    .o_busy(busy), .o_done(done), .o_pass(pass),
`ifdef TT_SWEEP_FIRST_FAIL_EN
    .o_fail_valid(fail_valid), .o_first_fail(first_fail),
`endif
    .o_state(st)
  );

  tt_sweep_capture #(.SETTLE_CYCLES(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_expected(expected1), .i_y(y1),
    .o_a(a1), .o_b(b1), .o_c(c1), .o_d(d1), .o_table(tbl1),
    .o_busy(busy1), .o_done(done1), .o_pass(pass1),
`ifdef TT_SWEEP_FIRST_FAIL_EN
    .o_fail_valid(fail_valid1), .o_first_fail(first_fail1),
`endif
    .o_state(st1)
  );

  // ---------------- unit-under-test models ----------------
  function automatic logic model_y(input int m, input logic [3:0] v);
    case (m)
      0:       return v[3];
      1:       return ^v;
      2:       return v[3] & v[2];
      default: return 1'b0;
    endcase
  endfunction

  assign y  = model_y(mode, {a, b, c, d});
  assign y1 = 1'b0;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic push_expect(input int m, input logic [15:0] expv);
    logic [15:0] t;
    logic        fv;
    logic [3:0]  fi;
    fv = 1'b0;
    fi = '0;
    for (int v = 0; v < 16; v++) begin
      t[v] = model_y(m, 4'(v));
      if (!fv && t[v] != expv[v]) begin
        fv = 1'b1;
        fi = 4'(v);
      end
    end
    exp_q.push_back(t);
    pass_q.push_back(t == expv);
    ffv_q.push_back(fv);
    ff_q.push_back(fi);
  endtask

  task automatic pop_compare(input string tag);
    logic [15:0] et;
    logic        ep, efv;
    logic [3:0]  eff;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(exp_q.size()), 1);
      return;
    end
    et  = exp_q.pop_front();
    ep  = pass_q.pop_front();
    efv = ffv_q.pop_front();
    eff = ff_q.pop_front();
    check({tag, "_table"}, 32'(tbl), 32'(et));
    check({tag, "_pass"}, 32'(pass), 32'(ep));
    check({tag, "_vec15"}, 32'({a, b, c, d}), 32'hF);
`ifdef TT_SWEEP_FIRST_FAIL_EN
    check({tag, "_fail_valid"}, 32'(fail_valid), 32'(efv));
    check({tag, "_first_fail"}, 32'(first_fail), 32'(eff));
`else
    if (efv) eff = eff;
`endif
  endtask

  // ---------------- drivers ----------------
  task automatic wait_done(input bit change_mid, input logic [15:0] late_exp, output int cyc);
    cyc = 0;
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (change_mid && cyc == 10) expected = late_exp;
    end
  endtask

  task automatic sweep(input string tag, input int m, input logic [15:0] expv,
                       input bit change_mid);
    int cyc;
    @(negedge clk);
    mode = m; expected = expv; start = 1'b1;
    push_expect(m, expv);
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_start"}, 32'(busy), 1);
    check({tag, "_done_cleared"}, 32'(done), 0);
    check({tag, "_vec0"}, 32'({a, b, c, d}), 0);
    wait_done(change_mid, ~expv, cyc);
    check({tag, "_latency"}, 32'(cyc), 48);
    check({tag, "_busy_end"}, 32'(busy), 0);
    pop_compare(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; expected = '0; mode = 0;
    start1 = 1'b0; expected1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_table", 32'(tbl), 0);
    check("rst_flags", 32'({busy, done, pass}), 0);
    check("rst_state", 32'(st), 0);
    @(negedge clk); rst = 1'b0;

    sweep("loop_a", 0, 16'hFF00, 1'b0);
    sweep("xor_ok", 1, 16'h6996, 1'b0);
    sweep("xor_bad", 1, 16'h6997, 1'b0);

    // SETTLE_CYCLES = 1 instance, response tied low
    @(negedge clk); start1 = 1'b1; expected1 = 16'h0000;
    @(posedge clk); #1;
    start1 = 1'b0;
    check("s1_busy_start", 32'(busy1), 1);
    cyc = 0;
    while (!done1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("s1_latency", 32'(cyc), 32);
    check("s1_table", 32'(tbl1), 0);
    check("s1_pass", 32'(pass1), 1);

    // asynchronous reset in the middle of vector 7
    @(negedge clk); mode = 1; expected = 16'h6996; start = 1'b1;
    push_expect(1, 16'h6996);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while ({a, b, c, d} != 4'd7 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("mid_reached_vec7", 32'({a, b, c, d}), 7);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_vec", 32'({a, b, c, d}), 0);
    check("mid_rst_table", 32'(tbl), 0);
    check("mid_rst_flags", 32'({busy, done, pass}), 0);
    check("mid_rst_state", 32'(st), 0);
    exp_q.delete(); pass_q.delete(); ffv_q.delete(); ff_q.delete();
    @(negedge clk); rst = 1'b0;
    sweep("after_rst", 1, 16'h6996, 1'b0);

    // start held high through a whole sweep
    @(negedge clk); mode = 0; expected = 16'hFF00; start = 1'b1;
    push_expect(0, 16'hFF00);
    @(posedge clk); #1;
    wait_done(1'b0, 16'h0, cyc);
    check("hold_latency", 32'(cyc), 48);
    pop_compare("hold1");
    push_expect(0, 16'hFF00);
    @(posedge clk); #1;
    start = 1'b0;
    check("hold_restart_done", 32'(done), 0);
    check("hold_restart_busy", 32'(busy), 1);
    check("hold_restart_table", 32'(tbl), 0);
    check("hold_restart_vec", 32'({a, b, c, d}), 0);
    wait_done(1'b0, 16'h0, cyc);
    check("hold2_latency", 32'(cyc), 48);
    pop_compare("hold2");

    // expected table changes after start must not matter
    sweep("late_exp", 2, 16'hF000, 1'b1);

    // random expected tables against random response functions
    for (int i = 0; i < 3; i++) begin
      sweep("rand", int'($urandom_range(0, 3)), 16'($urandom_range(0, 65535)), 1'b0);
    end

    check("sb_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
